// File: rtl/boot_copy_controller.sv
// Boot sequencer: copies a fixed ROM image into instruction RAM, stalls fetch
// with NOPs during the copy, then hands the RAM read port to the fetch stage.
module boot_copy_controller #(
  parameter int          ROM_WORDS = 256,
  parameter logic [63:0] COPY_BASE = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] romAddress,
  input  logic [31:0] romInstruction,
  output logic        ramWriteValid,
  input  logic        ramWriteReady,
  output logic [63:0] ramWriteAddress,
  output logic [31:0] ramWriteData,
  input  logic [63:0] coreFetchAddress,
  output logic [31:0] coreFetchInstruction,
  output logic [63:0] ramReadAddress,
  input  logic [31:0] ramReadData,
  output logic        coreHold,
  output logic        done,
  output logic [31:0] checksum,
  output logic [1:0]  state_dbg
);

  // Handshake: a write transfers on a rising edge where ramWriteValid and
  // ramWriteReady are both high; address and data hold while ready is low.

  localparam logic [7:0]  LAST_INDEX = 8'(ROM_WORDS - 1);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  index;
  logic [31:0] sum;
  logic        accept;
  logic        last_accept;
  logic        restart;

  assign accept      = (state == COPY) && ramWriteReady;
  assign last_accept = accept && (index == LAST_INDEX);
  assign restart     = (state == RUN) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = COPY;
      COPY:    if (last_accept) state_next = RUN;
      RUN:     if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index stops at the last word: entering RUN wins over the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= 8'd0;
      sum   <= 32'd0;
    end else if (state == IDLE || restart) begin
      index <= 8'd0;
      sum   <= 32'd0;
    end else if (accept) begin
      sum <= sum + romInstruction;
      if (index != LAST_INDEX) index <= index + 8'd1;
    end
  end

  always_comb begin
    ramWriteValid        = 1'b0;
    coreHold             = 1'b1;
    done                 = 1'b0;
    ramReadAddress       = 64'd0;
    coreFetchInstruction = NOP;
    case (state)
      COPY: ramWriteValid = 1'b1;
      RUN: begin
        coreHold             = 1'b0;
        done                 = 1'b1;
        ramReadAddress       = coreFetchAddress;
        coreFetchInstruction = ramReadData;
      end
      default: ;
    endcase
  end

  assign romAddress      = {54'd0, index, 2'b00};
  assign ramWriteAddress = COPY_BASE + romAddress;
  assign ramWriteData    = romInstruction;
  assign checksum        = sum;
  assign state_dbg       = state;

endmodule

// File: doc/boot_copy_controller.md
# boot_copy_controller

Boot sequencer between the hard-coded instruction ROM, the writable instruction RAM and the core's fetch stage. After reset, or on request, it copies a fixed-size image word by word from ROM into RAM through a valid/ready write port. It holds the core in a fetch-stall with NOP injection while copying, then hands the RAM read port to the fetch stage. It also accumulates a 32-bit additive checksum of the copied image so that load integrity can be checked.

## Interface
Parameters:
- ROM_WORDS, 256: number of 32-bit words copied; legal range 1..256.
- COPY_BASE, 64'h0: RAM byte address of the first copied word; 4-byte aligned.

Ports:
- clk, input, 1: single clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: re-boot request; sampled only in RUN.
- romAddress, output, 64: ROM byte address, index*4; ROM read is combinational.
- romInstruction, input, 32: ROM data for romAddress.
- ramWriteValid, output, 1: write request.
- ramWriteReady, input, 1: RAM accepts the write on the edge where valid and ready are both high.
- ramWriteAddress, output, 64: COPY_BASE + index*4.
- ramWriteData, output, 32: equals romInstruction.
- coreFetchAddress, input, 64: fetch-stage PC.
- coreFetchInstruction, output, 32: instruction returned to the fetch stage.
- ramReadAddress, output, 64: RAM read address; RAM read is combinational.
- ramReadData, input, 32: RAM data for ramReadAddress.
- coreHold, output, 1: stall for the fetch stage/PC; high whenever the block is not in RUN.
- done, output, 1: high in RUN.
- checksum, output, 32: modulo-2^32 sum of all words accepted in the current copy.

## Operation
- State machine, three states:
  - IDLE: always advances to COPY on the next edge. On entry, index and checksum are cleared.
  - COPY: the block presents the word at index.
    - Each accepted write adds ramWriteData to checksum and increments index.
    - When the write with index == ROM_WORDS-1 is accepted, the next state is RUN.
  - RUN: start high at an edge moves the block to IDLE, which restarts the copy.
- Index is 8 bits wide, enough for ROM_WORDS up to 256. It never wraps: the transition to RUN takes precedence over incrementing past the last word.
- ramWriteValid is 1 only in COPY. While ramWriteReady is low, address and data hold stable.
- RUN:
  - ramReadAddress = coreFetchAddress.
  - coreFetchInstruction = ramReadData.
  - coreHold = 0 and done = 1.
- All other states:
  - ramReadAddress = 0.
  - coreFetchInstruction = 32'h00000013 (NOP).
  - coreHold = 1 and done = 0.
- start is ignored in IDLE and COPY.
- checksum is only cleared on entry to IDLE, so it holds its final value in RUN until the next re-boot.
- Reset mid-copy: the copy is abandoned immediately with no further writes, and the sequence restarts from index 0 after reset is released.

## Timing
- Reset values:
  - state = IDLE, index = 0, checksum = 0.
  - ramWriteValid = 0, coreHold = 1, done = 0.
  - coreFetchInstruction = NOP, romAddress = 0.
  - ramWriteAddress = COPY_BASE, ramReadAddress = 0.
- All state, index and checksum registers update on the rising clk edge. All outputs are combinational functions of those registers and of the pass-through inputs, with no added latency.
- Cycle numbering: edge 0 is the first rising edge after reset deasserts.
  - Edge 0: IDLE→COPY.
  - With ramWriteReady held high, word k is accepted at edge k+1.
  - RUN is entered at edge ROM_WORDS; done rises in the cycle after that edge.
- Stalls: each cycle in COPY with ramWriteReady low adds exactly one cycle of latency.
- Re-boot: start sampled high in RUN at edge t gives IDLE after t and COPY after t+1. coreHold is high from the cycle after edge t.
- ROM_WORDS = 1: exactly one write, and RUN follows its acceptance edge.

## Test plan
- Reset, then ROM_WORDS=4 with ROM words 1, 2, 3, 4 and ramWriteReady always high -> writes to addresses 0x0, 0x4, 0x8, 0xC at edges 1–4; done=1 after edge 4; checksum=10.
- ramWriteReady low for 3 cycles during word 2 -> address 0x8 and data 3 held stable; no duplicate write; RUN reached 3 cycles later; checksum still 10.
- In COPY, coreFetchAddress=0x40 -> coreFetchInstruction=0x00000013 and coreHold=1. In RUN with ramReadData=0xDEADBEEF -> coreFetchInstruction=0xDEADBEEF and ramReadAddress=0x40.
- start pulse in RUN -> IDLE, then a full copy repeats from index 0 with checksum recomputed from 0. A start pulse asserted during COPY -> no effect.
- Assert reset after 2 accepted words -> ramWriteValid=0 immediately; after release, the copy restarts at COPY_BASE.
- COPY_BASE=0x1000 and ROM_WORDS=256 with all words 0xFFFFFFFF -> last write at 0x13FC; checksum=0xFFFFFF00; no index wrap and no 257th write.
